// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Stall watchdog: counts strobe cycles without a slave response and
// pulses expire on the last allowed stalled cycle.
module wb_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] cnt;

    assign expire = run && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || expire) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin on contention, no pre-emption,
// zero-gap handoff and a forced bus error when the slave stalls too long.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    state_t state;
    logic   rr;
    logic   sel0, sel1;
    logic   live0, live1;
    logic   release_now;
    logic   expire;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            rr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || !rr)) begin
                        state <= GNT0;
                        rr    <= 1'b1;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                        rr    <= 1'b0;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            state <= GNT1;
                            rr    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            state <= GNT0;
                            rr    <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel0    = (state == GNT0);
    assign sel1    = (state == GNT1);
    assign grant_o = {sel1, sel0};

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (sel0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
        end else if (sel1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
        end
    end

    // Responses only reach an owner still in its cycle, so a late ack
    // after cyc drops is swallowed.
    assign live0 = sel0 && m0_cyc_i && m0_stb_i;
    assign live1 = sel1 && m1_cyc_i && m1_stb_i;

    assign m0_dat_o = sel0 ? s_dat_i : '0;
    assign m1_dat_o = sel1 ? s_dat_i : '0;
    assign m0_ack_o = live0 && s_ack_i;
    assign m1_ack_o = live1 && s_ack_i;
    assign m0_err_o = live0 && (s_err_i || expire);
    assign m1_err_o = live1 && (s_err_i || expire);

    assign release_now = (sel0 && !m0_cyc_i) || (sel1 && !m1_cyc_i);

    wb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .run   (s_stb_o && !s_ack_i && !s_err_i),
        .clr   (s_ack_i || s_err_i || release_now),
        .expire(expire)
    );

    assign timeout_o = expire;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: per-cycle vector table
// through a scoreboard queue, plus an async-reset sequence.
module tb_wb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_adr = 32'h0000_0100;
    logic [31:0] m1_adr = 32'h0000_0200;
    logic [31:0] m0_dat = 32'hAAAA_0000;
    logic [31:0] m1_dat = 32'hBBBB_0000;
    logic [3:0]  m0_sel = 4'hF;
    logic [3:0]  m1_sel = 4'h3;
    logic        m0_we = 1'b1;
    logic        m1_we = 1'b0;
    logic        m0_cyc = 1'b0, m0_stb = 1'b0;
    logic        m1_cyc = 1'b0, m1_stb = 1'b0;
    logic [31:0] m0_rd, m1_rd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] s_adr, s_wdat, s_rdat = '0;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb;
    logic        s_ack = 1'b0, s_err = 1'b0;
    logic [1:0]  grant;
    logic        tmo;

    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    wb_master_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i(clk),     .wb_rst_i(rst),
        .m0_adr_i(m0_adr),  .m0_dat_i(m0_dat),
        .m0_sel_i(m0_sel),  .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc),  .m0_stb_i(m0_stb),
        .m0_dat_o(m0_rd),   .m0_ack_o(m0_ack),
        .m0_err_o(m0_err),
        .m1_adr_i(m1_adr),  .m1_dat_i(m1_dat),
        .m1_sel_i(m1_sel),  .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc),  .m1_stb_i(m1_stb),
        .m1_dat_o(m1_rd),   .m1_ack_o(m1_ack),
        .m1_err_o(m1_err),
        .s_adr_o(s_adr),    .s_dat_o(s_wdat),
        .s_sel_o(s_sel),    .s_we_o(s_we),
        .s_cyc_o(s_cyc),    .s_stb_o(s_stb),
        .s_dat_i(s_rdat),   .s_ack_i(s_ack),
        .s_err_i(s_err),
        .grant_o(grant),    .timeout_o(tmo)
    );

    typedef struct {
        logic        rst, c0, s0, c1, s1, ack, err;
        logic [31:0] sd;
        logic [1:0]  g;
        logic        sc, ss, a0, e0, a1, e1, to;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h want %h", n, act, exp);
    endtask

    task automatic check_vec(input int r, input vec_t e);
        logic [31:0] ea, ed;
        logic [3:0]  es;
        logic        ew;
        ea = 0; ed = 0; es = 0; ew = 0;
        if (e.g == 2'b01) begin
            ea = 32'h100; ed = 32'hAAAA_0000; es = 4'hF; ew = 1;
        end else if (e.g == 2'b10) begin
            ea = 32'h200; ed = 32'hBBBB_0000; es = 4'h3; ew = 0;
        end
        chk($sformatf("r%0d grant", r), 32'(grant), 32'(e.g));
        chk($sformatf("r%0d s_cyc", r), 32'(s_cyc), 32'(e.sc));
        chk($sformatf("r%0d s_stb", r), 32'(s_stb), 32'(e.ss));
        chk($sformatf("r%0d s_adr", r), s_adr, ea);
        chk($sformatf("r%0d s_dat", r), s_wdat, ed);
        chk($sformatf("r%0d s_sel", r), 32'(s_sel), 32'(es));
        chk($sformatf("r%0d s_we", r), 32'(s_we), 32'(ew));
        chk($sformatf("r%0d m0_ack", r), 32'(m0_ack), 32'(e.a0));
        chk($sformatf("r%0d m0_err", r), 32'(m0_err), 32'(e.e0));
        chk($sformatf("r%0d m1_ack", r), 32'(m1_ack), 32'(e.a1));
        chk($sformatf("r%0d m1_err", r), 32'(m1_err), 32'(e.e1));
        chk($sformatf("r%0d timeout", r), 32'(tmo), 32'(e.to));
        chk($sformatf("r%0d m0_dat", r), m0_rd, e.d0);
        chk($sformatf("r%0d m1_dat", r), m1_rd, e.d1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t v;
        // rst c0 s0 c1 s1 ack err sd | g sc ss a0 e0 a1 e1 to d0 d1
        tbl.push_back('{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
        // m0 read, slave answers on third granted cycle
        tbl.push_back('{0,1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,1,0,0,0,0,0, 1,1,1,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,1,0,0,0,0,0, 1,1,1,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,1,0,0,1,0,32'hDEADBEEF,
                        1,1,1,1,0,0,0,0,32'hDEADBEEF,0});
        tbl.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
        // simultaneous request after reset, gapless handoff
        tbl.push_back('{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,1,1,1,0,0,0, 0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,1,1,1,1,0,32'h11111111,
                        1,1,1,1,0,0,0,0,32'h11111111,0});
        tbl.push_back('{0,0,0,1,1,1,0,0, 1,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,1,1,1,0,32'h22222222,
                        2,1,1,0,0,1,0,0,0,32'h22222222});
        tbl.push_back('{0,0,0,0,0,0,0,0, 2,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
        // m0 keeps bus over 3 transfers, second with ack+err
        tbl.push_back('{0,1,1,1,1,0,0,0, 0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,1,1,1,1,0,32'hA0,
                        1,1,1,1,0,0,0,0,32'hA0,0});
        tbl.push_back('{0,1,0,1,1,0,0,0, 1,1,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,1,1,1,1,1,32'hA1,
                        1,1,1,1,1,0,0,0,32'hA1,0});
        tbl.push_back('{0,1,1,1,1,1,0,32'hA2,
                        1,1,1,1,0,0,0,0,32'hA2,0});
        tbl.push_back('{0,0,0,1,1,0,0,0, 1,0,0,0,0,0,0,0,0,0});
        // m1 stalls: forced error on 4th stalled cycle, then restart
        tbl.push_back('{0,0,0,1,1,0,0,0, 2,1,1,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,1,1,0,0,0, 2,1,1,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,1,1,0,0,0, 2,1,1,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,1,1,0,0,0, 2,1,1,0,0,0,1,1,0,0});
        tbl.push_back('{0,0,0,1,1,0,0,0, 2,1,1,0,0,0,0,0,0,0});

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            v = tbl[i];
            rst = v.rst;
            m0_cyc = v.c0; m0_stb = v.s0;
            m1_cyc = v.c1; m1_stb = v.s1;
            s_ack = v.ack; s_err = v.err;
            s_rdat = v.sd;
            sb.push_back(v);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("scoreboard empty", 1, 0);
            end else begin
                check_vec(i, sb.pop_front());
            end
        end

        // async reset while m1 owns the bus with stb high
        @(posedge clk);
        #1;
        chk("pre-rst grant", 32'(grant), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst s_cyc", 32'(s_cyc), 0);
        chk("arst s_stb", 32'(s_stb), 0);
        chk("arst grant", 32'(grant), 0);
        chk("arst m1_err", 32'(m1_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 1; m1_stb = 1;
        @(negedge clk);
        chk("post-rst idle grant", 32'(grant), 0);
        @(negedge clk);
        chk("post-rst grant", 32'(grant), 32'h1);
        chk("post-rst s_adr", s_adr, 32'h100);
        chk("post-rst s_cyc", 32'(s_cyc), 1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
